// File: rtl/mips_alu_pkg.sv
// Shared encodings for the MIPS ALU: main-control class codes, ALU control
// codes, and the decode from (alu_op, funct) to the ALU control code.
package mips_alu_pkg;

  typedef enum logic [2:0] {
    ALU_OP_FUNCT = 3'b000,
    ALU_OP_ADD   = 3'b001,
    ALU_OP_AND   = 3'b010,
    ALU_OP_OR    = 3'b011,
    ALU_OP_SUB   = 3'b100,
    ALU_OP_SLT   = 3'b101,
    ALU_OP_ADD6  = 3'b110,
    ALU_OP_ADD7  = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    CTR_ADD  = 3'b000,
    CTR_SUB  = 3'b001,
    CTR_AND  = 3'b010,
    CTR_OR   = 3'b011,
    CTR_XOR  = 3'b100,
    CTR_NOR  = 3'b101,
    CTR_SLT  = 3'b110,
    CTR_SLTU = 3'b111
  } alu_ctr_e;

  // R-type instructions pass funct straight through; other classes force a code.
  function automatic alu_ctr_e decode_ctr(input logic [2:0] alu_op, input logic [2:0] funct);
    alu_ctr_e ctr;
    case (alu_op_e'(alu_op))
      ALU_OP_FUNCT: ctr = alu_ctr_e'(funct);
      ALU_OP_AND:   ctr = CTR_AND;
      ALU_OP_OR:    ctr = CTR_OR;
      ALU_OP_SUB:   ctr = CTR_SUB;
      ALU_OP_SLT:   ctr = CTR_SLT;
      default:      ctr = CTR_ADD;
    endcase
    return ctr;
  endfunction

endpackage

// File: rtl/adder32.sv
// Ripple-carry adder with carry-in and carry-out; shared by the ALU and the
// two program-counter paths.
module adder32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1]   = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/mips_alu_unit.sv
// Single-cycle MIPS ALU with PC increment and branch-target generation,
// followed by one output register stage.
module mips_alu_unit
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       alu_op,
  input  logic [2:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] pc,
  input  logic [5:0]       imm6,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic [2:0]       alu_ctr,
  output logic [WIDTH-1:0] pc_plus1,
  output logic [WIDTH-1:0] branch_pc
);

  // Valid semantics: there is no back-pressure. A beat is accepted on every
  // rising edge where in_valid=1 and rst=0; out_valid then pulses high for
  // exactly the cycle its registered result is presented.

  localparam int MSB = WIDTH - 1;

  alu_ctr_e         ctr;
  logic             is_sub;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] sum;
  logic             add_cout;
  logic             add_ovf;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] br_target;
  logic             pc_cout_unused;
  logic             br_cout_unused;
  logic [WIDTH-1:0] next_result;
  logic             next_carry;
  logic             next_ovf;

  always_comb begin
    ctr    = decode_ctr(alu_op, funct);
    is_sub = (ctr == CTR_SUB) || (ctr == CTR_SLT) || (ctr == CTR_SLTU);
    add_b  = is_sub ? ~op_b : op_b;
  end

  adder32 #(.WIDTH(WIDTH)) u_alu_add (
    .a(op_a), .b(add_b), .cin(is_sub), .sum(sum), .cout(add_cout)
  );

  assign add_ovf = (op_a[MSB] == add_b[MSB]) && (sum[MSB] != op_a[MSB]);
  assign imm_ext = {{(WIDTH-6){imm6[5]}}, imm6};

  // Both PC paths fold the +1 into the carry-in so they evaluate in parallel.
  adder32 #(.WIDTH(WIDTH)) u_pc_inc (
    .a(pc), .b('0), .cin(1'b1), .sum(pc_inc), .cout(pc_cout_unused)
  );

  adder32 #(.WIDTH(WIDTH)) u_br_target (
    .a(pc), .b(imm_ext), .cin(1'b1), .sum(br_target), .cout(br_cout_unused)
  );

  always_comb begin
    next_result = '0;
    next_carry  = 1'b0;
    next_ovf    = 1'b0;
    case (ctr)
      CTR_ADD, CTR_SUB: begin
        next_result = sum;
        next_carry  = add_cout;
        next_ovf    = add_ovf;
      end
      CTR_AND:  next_result = op_a & op_b;
      CTR_OR:   next_result = op_a | op_b;
      CTR_XOR:  next_result = op_a ^ op_b;
      CTR_NOR:  next_result = ~(op_a | op_b);
      CTR_SLT:  next_result = {{(WIDTH-1){1'b0}}, sum[MSB] ^ add_ovf};
      CTR_SLTU: next_result = {{(WIDTH-1){1'b0}}, ~add_cout};
      default:  next_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      alu_ctr   <= 3'b000;
      pc_plus1  <= '0;
      branch_pc <= '0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      result    <= next_result;
      zero      <= ~|next_result;
      carry_out <= next_carry;
      overflow  <= next_ovf;
      alu_ctr   <= ctr;
      pc_plus1  <= pc_inc;
      branch_pc <= br_target;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_alu_unit.sv
// Directed and randomized checks of mips_alu_unit against an arithmetic
// reference model of the ALU, PC increment and branch target.
module tb_mips_alu_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [2:0]   alu_op;
  logic [2:0]   funct;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] pc;
  logic [5:0]   imm6;
  logic         out_valid;
  logic [W-1:0] result;
  logic         zero;
  logic         carry_out;
  logic         overflow;
  logic [2:0]   alu_ctr;
  logic [W-1:0] pc_plus1;
  logic [W-1:0] branch_pc;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic         valid;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         ovf;
    logic [2:0]   ctr;
    logic [W-1:0] pcp1;
    logic [W-1:0] bpc;
  } out_t;

  out_t model;
  out_t exp_q[$];

  mips_alu_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_op(alu_op), .funct(funct),
    .op_a(op_a), .op_b(op_b), .pc(pc), .imm6(imm6), .out_valid(out_valid),
    .result(result), .zero(zero), .carry_out(carry_out), .overflow(overflow),
    .alu_ctr(alu_ctr), .pc_plus1(pc_plus1), .branch_pc(branch_pc)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on 64-bit values
  function automatic out_t ref_model(input logic [2:0] op, input logic [2:0] f,
                                     input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [W-1:0] p, input logic [5:0] imm);
    out_t   o;
    longint ua, ub, sa, sb, s, full;
    int     c;
    o       = '0;
    o.valid = 1'b1;
    case (op)
      3'd0:    c = int'(f);
      3'd2:    c = 2;
      3'd3:    c = 3;
      3'd4:    c = 1;
      3'd5:    c = 6;
      default: c = 0;
    endcase
    ua = longint'(a);
    ub = longint'(b);
    sa = $signed(a);
    sb = $signed(b);
    case (c)
      0: begin
        full     = ua + ub;
        o.result = full[W-1:0];
        o.carry  = full[W];
        s        = sa + sb;
        o.ovf    = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      1: begin
        full     = ua - ub;
        o.result = full[W-1:0];
        o.carry  = (ua >= ub);
        s        = sa - sb;
        o.ovf    = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      2: o.result = a & b;
      3: o.result = a | b;
      4: o.result = a ^ b;
      5: o.result = ~(a | b);
      6: o.result = (sa < sb) ? 1 : 0;
      default: o.result = (ua < ub) ? 1 : 0;
    endcase
    o.zero = (o.result == 0);
    o.ctr  = 3'(c);
    full   = longint'(p) + 1;
    o.pcp1 = full[W-1:0];
    full   = longint'(p) + 1 + longint'($signed(imm));
    o.bpc  = full[W-1:0];
    return o;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: apply one cycle of inputs, advance the model, sample #1 after the edge
  task automatic step(input logic r, input logic v, input logic [2:0] op, input logic [2:0] f,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] p, input logic [5:0] imm);
    out_t e;
    rst = r; in_valid = v; alu_op = op; funct = f;
    op_a = a; op_b = b; pc = p; imm6 = imm;
    if (r)      model = '0;
    else if (v) model = ref_model(op, f, a, b, p, imm);
    else        model.valid = 1'b0;
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("out_valid", 64'(out_valid), 64'(e.valid));
    check("result",    64'(result),    64'(e.result));
    check("zero",      64'(zero),      64'(e.zero));
    check("carry_out", 64'(carry_out), 64'(e.carry));
    check("overflow",  64'(overflow),  64'(e.ovf));
    check("alu_ctr",   64'(alu_ctr),   64'(e.ctr));
    check("pc_plus1",  64'(pc_plus1),  64'(e.pcp1));
    check("branch_pc", 64'(branch_pc), 64'(e.bpc));
  endtask

  function automatic logic [W-1:0] rand_word(input logic [W-1:0] other);
    case ($urandom_range(0, 4))
      0:       return W'($urandom_range(0, 15));
      1: begin
        case ($urandom_range(0, 3))
          0:       return 32'h7FFF_FFFF;
          1:       return 32'h8000_0000;
          2:       return 32'hFFFF_FFFF;
          default: return 32'h0000_0000;
        endcase
      end
      2:       return other;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic [W-1:0] a, b, held;
    model = '0;
    rst = 1'b1; in_valid = 1'b0; alu_op = '0; funct = '0;
    op_a = '0; op_b = '0; pc = '0; imm6 = '0;

    // Reset together with a valid operation: operation discarded
    step(1, 1, 3'b001, 3'b000, 5, 7, 10, 6'd3);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result",    64'(result),    64'd0);
    check("rst_pc_plus1",  64'(pc_plus1),  64'd0);
    check("rst_branch_pc", 64'(branch_pc), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 3'b001, 3'b000, $urandom, $urandom, $urandom, 6'($urandom));
      check("idle_out_valid", 64'(out_valid), 64'd0);
      check("idle_result",    64'(result),    64'd0);
    end

    // Directed cases
    step(0, 1, 3'b001, 3'b000, 5, 7, 10, 6'b111110);
    check("add_result", 64'(result), 64'd12);
    check("add_zero",   64'(zero),   64'd0);
    check("add_carry",  64'(carry_out), 64'd0);
    check("add_ovf",    64'(overflow),  64'd0);
    check("add_ctr",    64'(alu_ctr),   64'd0);
    check("br_pcp1",    64'(pc_plus1),  64'd11);
    check("br_target",  64'(branch_pc), 64'd9);
    step(0, 1, 3'b100, 3'b000, 32'h0000_1234, 32'h0000_1234, 32'hFFFF_FFFF, 6'd0);
    check("sub_eq_result", 64'(result),    64'd0);
    check("sub_eq_zero",   64'(zero),      64'd1);
    check("sub_eq_carry",  64'(carry_out), 64'd1);
    check("pc_wrap",       64'(pc_plus1),  64'd0);
    step(0, 1, 3'b000, 3'b000, 32'h7FFF_FFFF, 32'h1, 0, 6'd0);
    check("ovf_result", 64'(result),   64'h8000_0000);
    check("ovf_flag",   64'(overflow), 64'd1);
    step(0, 1, 3'b000, 3'b110, 32'hFFFF_FFFF, 32'h1, 0, 6'd0);
    check("slt_result", 64'(result), 64'd1);
    step(0, 1, 3'b000, 3'b111, 32'hFFFF_FFFF, 32'h1, 0, 6'd0);
    check("sltu_result", 64'(result), 64'd0);
    check("sltu_zero",   64'(zero),   64'd1);

    // Hold after a valid result
    step(0, 1, 3'b011, 3'b000, 32'h00F0_0000, 32'h0000_000F, 100, 6'd31);
    held = model.result;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 3'($urandom), 3'($urandom), $urandom, $urandom, $urandom, 6'($urandom));
      check("hold_result", 64'(result), 64'(held));
      check("hold_valid",  64'(out_valid), 64'd0);
    end

    // Randomized traffic, including back-to-back beats and mid-stream resets
    for (int i = 0; i < 600; i++) begin
      a = rand_word(32'h0);
      b = rand_word(a);
      step(($urandom_range(0, 60) == 0), ($urandom_range(0, 4) != 0),
           3'($urandom), 3'($urandom), a, b, rand_word(32'h0), 6'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_alu_unit.md
MIPS_ALU_UNIT -- requirements
Module: mips_alu_unit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and rst.
REQ-002 Parameter WIDTH, default 32, SHALL set the datapath width in bits.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  SHALL qualify the operands and control inputs for capture this cycle.
REQ-006 alu_op  input  3  main-control ALU class code.
REQ-007 funct  input  3  R-type function field (instruction bits 2:0).
REQ-008 op_a  input  WIDTH  first operand (rs).
REQ-009 op_b  input  WIDTH  second operand (rt, or the already-extended immediate).
REQ-010 pc  input  WIDTH  current program counter (word-addressed).
REQ-011 imm6  input  6  raw immediate field used for the branch offset.
REQ-012 out_valid  output  1  SHALL be high when the registered outputs hold a new result.
REQ-013 result  output  WIDTH  registered ALU result.
REQ-014 zero  output  1  registered flag, high when result is all zeros.
REQ-015 carry_out  output  1  registered adder carry for ADD/SUB; 0 for other operations.
REQ-016 overflow  output  1  registered signed overflow for ADD/SUB; 0 for other operations.
REQ-017 alu_ctr  output  3  registered decoded ALU control code.
REQ-018 pc_plus1  output  WIDTH  registered value of pc + 1.
REQ-019 branch_pc  output  WIDTH  registered value of pc + 1 + sign_extend(imm6).

Function
REQ-020 ALU control decode SHALL be as follows:
- alu_op 000 -> alu_ctr = funct.
- alu_op 001 -> ADD.
- alu_op 010 -> AND.
- alu_op 011 -> OR.
- alu_op 100 -> SUB.
- alu_op 101 -> SLT.
- alu_op 110 -> ADD.
- alu_op 111 -> ADD.
REQ-021 alu_ctr encodings SHALL be:
- 000 ADD.
- 001 SUB.
- 010 AND.
- 011 OR.
- 100 XOR.
- 101 NOR.
- 110 SLT (signed).
- 111 SLTU (unsigned).
REQ-022 ADD SHALL compute op_a + op_b modulo 2^WIDTH; carry_out is the bit-WIDTH carry.
REQ-023 SUB SHALL compute op_a + ~op_b + 1, using the same adder with carry-in 1; carry_out = 1 means no borrow.
REQ-024 overflow SHALL be high when both adder inputs (after the ~op_b inversion for SUB) have equal sign bits and the sum sign differs from them.
REQ-025 SLT SHALL return 1 when op_a < op_b as signed, computed as sum_msb XOR overflow of the subtraction; otherwise 0. Upper bits SHALL be zero.
REQ-026 SLTU SHALL return 1 when op_a < op_b as unsigned, i.e. NOT carry_out of the subtraction; otherwise 0.
REQ-027 zero SHALL be the NOR of all result bits, so branch logic can use it directly for beq/bne.
REQ-028 Output latency SHALL be exactly 1 cycle: inputs captured with in_valid=1 at edge N appear at edge N, with out_valid=1 for one cycle.
REQ-029 When in_valid=0, out_valid SHALL go to 0 at the next edge and all data outputs SHALL hold their previous values.
REQ-030 Back-to-back in_valid SHALL produce one result per cycle with no bubbles.
REQ-031 pc_plus1 and branch_pc SHALL wrap modulo 2^WIDTH; imm6 SHALL be sign-extended from bit 5.

Reset
REQ-032 While rst=1 at a rising edge, all outputs SHALL become 0 (out_valid, result, zero, carry_out, overflow, alu_ctr, pc_plus1, branch_pc).
REQ-033 rst SHALL take priority over in_valid in the same cycle; an operation presented during reset SHALL be discarded.

Structure
REQ-034 The alu_op and alu_ctr encodings SHALL be defined as localparams/enums in a shared package, mips_alu_pkg.
REQ-035 A single ripple- or carry-lookahead adder sub-module, adder32 (a, b, cin -> sum, cout), SHALL be instantiated three times: ALU add/sub, PC increment, and branch target.
REQ-036 Decode and the operation multiplexer SHALL be combinational, followed by one output register stage.

Verification
REQ-037 ADD: alu_op=001, op_a=5, op_b=7 -> next cycle result=12, zero=0, carry_out=0, overflow=0, alu_ctr=000.
REQ-038 Equal-branch SUB: alu_op=100, op_a=op_b=0x0000_1234 -> result=0, zero=1, carry_out=1.
REQ-039 Signed overflow: alu_op=000, funct=000, op_a=0x7FFF_FFFF, op_b=1 -> result=0x8000_0000, overflow=1.
REQ-040 SLT vs SLTU with op_a=0xFFFF_FFFF, op_b=1:
- funct=110 -> result=1.
- funct=111 -> result=0.
REQ-041 Branch target: pc=10, imm6=6'b111110 -> pc_plus1=11, branch_pc=9; pc=0xFFFF_FFFF -> pc_plus1=0.
REQ-042 Reset and hold: assert rst together with in_valid=1 -> all outputs 0; then apply in_valid=0 for 3 cycles -> out_valid=0 and outputs unchanged.
